binop_sequencer: RTL
====================

# binop_sequencer

Sequences one WebAssembly binary numeric instruction (e.g. `i32.ne`, opcode 0x47) through the CPU datapath. It pops operand B then operand A from the operand stack, issues them with the opcode to the ALU, waits for completion and pushes the result back. Stack underflow, overflow and ALU faults become a sticky trap code. Sits between the `cpu` decode stage and the shared operand stack / ALU.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width (stack entry width).
- `TIMEOUT`, 16, max cycles waiting for `alu_done` (used only with `BINOP_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cmd_valid`  in  1  decode presents a binary op.
- `cmd_op`  in  8  wasm opcode.
- `cmd_ready`  out  1  high only in IDLE with no trap.
- `stack_data`  in  WIDTH  current top of stack (combinational).
- `stack_empty`  in  1  stack holds no entries.
- `stack_full`  in  1  stack cannot accept a push.
- `stack_pop`  out  1  pop top entry at this edge.
- `stack_push`  out  1  push `stack_push_data` at this edge.
- `stack_push_data`  out  WIDTH  result to push.
- `alu_start`  out  1  one-cycle pulse; operands/op valid.
- `alu_op`  out  8  latched opcode.
- `alu_a`, `alu_b`  out  WIDTH  latched operands.
- `alu_done`  in  1  ALU result valid this cycle.
- `alu_result`  in  WIDTH  ALU result.
- `alu_trap`  in  1  ALU fault, sampled with `alu_done`.
- `done`  out  1  one-cycle pulse when result pushed.
- `trap`  out  3  0 none, 1 underflow, 2 overflow, 3 ALU fault, 4 timeout.

## Operation
- States: IDLE, POP_B, POP_A, EXEC, WAIT, PUSH, TRAP.
- IDLE: `cmd_ready`=1; on `cmd_valid` latch `cmd_op` into `alu_op`, go POP_B.
- POP_B: if `stack_empty` -> TRAP, trap=1; else latch `stack_data` into `alu_b`, assert `stack_pop`, go POP_A.
- POP_A: same with `alu_a`; go EXEC.
- EXEC: assert `alu_start`; if `alu_done` same cycle, handle as WAIT; else go WAIT.
- WAIT: on `alu_done`: `alu_trap`=1 -> TRAP, trap=3; else latch `alu_result`, go PUSH.
- PUSH: if `stack_full` -> TRAP, trap=2; else assert `stack_push` with latched result and `done`, go IDLE.
- TRAP: terminal; `cmd_ready`=0, all strobes 0, `trap` held until reset. Operand stack left as-is (popped entries not restored).
- Results passed unmodified; no width conversion (ALU produces zero-extended i32 results).
- `alu_done` outside EXEC/WAIT ignored.
- Reset values: state IDLE, `trap`=0, `alu_a`/`alu_b`/`alu_op`/`stack_push_data`=0, all strobes 0, `cmd_ready`=1 after reset deasserts.

## Timing
- Outputs are registered-state (Moore) decodes; `stack_pop`/`stack_push` act on the edge ending their cycle.
- Accept at edge N (IDLE): POP_B cycle N+1, POP_A N+2, EXEC N+3, PUSH N+4 (ALU done in EXEC), IDLE with `cmd_ready` N+5. Each extra ALU cycle adds one.
- `stack_empty` in POP_A reflects the POP_B pop (stack updates at edge).
- Back-to-back: next command accepted in the cycle after PUSH.
- Reset mid-operation: immediate return to IDLE, outputs to reset values; partially popped operands lost.

## Configuration
- `BINOP_TIMEOUT_EN` defined: counter cleared on entering EXEC, increments each EXEC/WAIT cycle without `alu_done`; reaching `TIMEOUT` -> TRAP, trap=4.
- Undefined: no counter; WAIT holds indefinitely; trap code 4 never produced.

## Test plan
- Stack [5,5] (5 top), cmd 0x47, mock ALU ne with done in EXEC -> pops 2, pushes 0, `done` at accept+4, trap 0.
- Stack [7,5], cmd 0x47 -> `alu_a`=7, `alu_b`=5, pushes 1; second command back-to-back accepted at accept+5.
- Stack holds one entry, cmd -> one pop, trap=1, `cmd_ready` stays 0, no `alu_start`.
- ALU done with `alu_trap`=1 after 3 wait cycles -> trap=3, no push; `stack_full` asserted in PUSH -> trap=2, no `done`.
- `BINOP_TIMEOUT_EN`, TIMEOUT=16, ALU never done -> trap=4 exactly 16 cycles after EXEC entry; without macro, still WAIT at 100 cycles.
- Assert `reset` during WAIT -> next cycle IDLE, trap 0, `cmd_ready`=1, no push.

Source files
------------

// File: rtl/binop_sequencer.sv
// Sequences one wasm binary numeric op: pop B, pop A, run the ALU, push the result.
// Optional ALU watchdog is compiled in with `define BINOP_TIMEOUT_EN (trap code 4).
module binop_sequencer #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] stack_data,
  input  logic             stack_empty,
  input  logic             stack_full,
  output logic             stack_pop,
  output logic             stack_push,
  output logic [WIDTH-1:0] stack_push_data,
  output logic             alu_start,
  output logic [7:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_trap,
  output logic             done,
  output logic [2:0]       trap
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP_B = 3'd1;
  localparam logic [2:0] S_POP_A = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_PUSH  = 3'd5;
  localparam logic [2:0] S_TRAP  = 3'd6;

  localparam logic [2:0] TRAP_NONE  = 3'd0;
  localparam logic [2:0] TRAP_UNDER = 3'd1;
  localparam logic [2:0] TRAP_OVER  = 3'd2;
  localparam logic [2:0] TRAP_ALU   = 3'd3;
  localparam logic [2:0] TRAP_TMO   = 3'd4;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("binop_sequencer: TIMEOUT must be at least 1");
  end

  logic [2:0]       state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       trap_q, trap_d;

`ifdef BINOP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    trap_d  = trap_q;
`ifdef BINOP_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          state_d = S_POP_B;
        end
      end
      S_POP_B: begin
        if (stack_empty) begin
          state_d = S_TRAP;
          trap_d  = TRAP_UNDER;
        end else begin
          b_d     = stack_data;
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        if (stack_empty) begin
          state_d = S_TRAP;
          trap_d  = TRAP_UNDER;
        end else begin
          a_d     = stack_data;
          state_d = S_EXEC;
`ifdef BINOP_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      // EXEC only differs from WAIT by the start pulse; a same-cycle done is handled here.
      S_EXEC, S_WAIT: begin
        if (alu_done) begin
          if (alu_trap) begin
            state_d = S_TRAP;
            trap_d  = TRAP_ALU;
          end else begin
            res_d   = alu_result;
            state_d = S_PUSH;
          end
        end else begin
          state_d = S_WAIT;
`ifdef BINOP_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_TRAP;
            trap_d  = TRAP_TMO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      S_PUSH: begin
        if (stack_full) begin
          state_d = S_TRAP;
          trap_d  = TRAP_OVER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      trap_q  <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      trap_q  <= trap_d;
    end
  end

`ifdef BINOP_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Strobes are state decodes, gated by the stack status that decides the branch.
  assign cmd_ready       = (state_q == S_IDLE);
  assign stack_pop       = ((state_q == S_POP_B) || (state_q == S_POP_A)) && !stack_empty;
  assign stack_push      = (state_q == S_PUSH) && !stack_full;
  assign done            = (state_q == S_PUSH) && !stack_full;
  assign alu_start       = (state_q == S_EXEC);
  assign alu_op          = op_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign stack_push_data = res_q;
  assign trap            = trap_q;

endmodule
